// File: rtl/scan_sequencer_if.sv
// Handshake and channel-select bundle between a scan controller and scan_sequencer.
interface scan_sequencer_if #(
    parameter int unsigned DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic               mode;
    logic [7:0]         mask;
    logic [DWELL_W-1:0] dwell;
    logic [2:0]         sel;
    logic               en;
    logic               busy;
    logic               done;
    logic               frame_tick;

    modport master (
        output start, stop, mode, mask, dwell,
        input  sel, en, busy, done, frame_tick
    );

    modport slave (
        input  start, stop, mode, mask, dwell,
        output sel, en, busy, done, frame_tick
    );
endinterface

// File: rtl/scan_sequencer.sv
// Walks the set bits of a channel mask in ascending order, driving sel/en to a 3-to-8 decoder
// with a programmable dwell per channel and a fixed blanking gap after each dwell.
module scan_sequencer #(
    parameter int unsigned DWELL_W    = 8,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    scan_sequencer_if.slave   bus
);
    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam bit          HAS_GAP  = (GAP_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               tick_q, tick_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0]   gcnt_q, gcnt_d;
    logic [7:0]         smask_q, smask_d;
    logic               smode_q, smode_d;
    logic [DWELL_W-1:0] sdwell_q, sdwell_d;
    logic               advance;
    logic [3:0]         nxt;

    // Remaining dwell cycles after the first; a zero dwell behaves as one cycle.
    function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
        return (d == '0) ? '0 : d - DWELL_W'(1);
    endfunction

    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        logic [2:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    // {found, index} of the lowest set bit strictly above cur.
    function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] cur);
        logic [3:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (3'(i) > cur)) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tick_q   <= 1'b0;
            cnt_q    <= '0;
            gcnt_q   <= '0;
            smask_q  <= '0;
            smode_q  <= 1'b0;
            sdwell_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            en_q     <= en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tick_q   <= tick_d;
            cnt_q    <= cnt_d;
            gcnt_q   <= gcnt_d;
            smask_q  <= smask_d;
            smode_q  <= smode_d;
            sdwell_q <= sdwell_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        en_d     = en_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        tick_d   = 1'b0;
        cnt_d    = cnt_q;
        gcnt_d   = gcnt_q;
        smask_d  = smask_q;
        smode_d  = smode_q;
        sdwell_d = sdwell_q;
        advance  = 1'b0;
        nxt      = next_above(smask_q, sel_q);

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop && (bus.mask != '0)) begin
                    smask_d  = bus.mask;
                    smode_d  = bus.mode;
                    sdwell_d = bus.dwell;
                    sel_d    = lowest_bit(bus.mask);
                    cnt_d    = dwell_load(bus.dwell);
                    en_d     = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = DWELL;
                end
            end
            DWELL: begin
                if (bus.stop) begin
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    if (HAS_GAP) begin
                        en_d    = 1'b0;
                        gcnt_d  = GAP_W'(GAP_LOAD);
                        state_d = GAP;
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
            end
            GAP: begin
                if (bus.stop) begin
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (gcnt_q == '0) begin
                    advance = 1'b1;
                end else begin
                    gcnt_d = gcnt_q - GAP_W'(1);
                end
            end
            default: begin
                en_d    = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        // Move to the next channel, or close the frame and either wrap or finish.
        if (advance) begin
            if (nxt[3]) begin
                sel_d   = nxt[2:0];
                cnt_d   = dwell_load(sdwell_q);
                en_d    = 1'b1;
                state_d = DWELL;
            end else begin
                tick_d = 1'b1;
                if (smode_q && (bus.mask != '0)) begin
                    smask_d  = bus.mask;
                    smode_d  = bus.mode;
                    sdwell_d = bus.dwell;
                    sel_d    = lowest_bit(bus.mask);
                    cnt_d    = dwell_load(bus.dwell);
                    en_d     = 1'b1;
                    state_d  = DWELL;
                end else begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    en_d    = 1'b0;
                    state_d = IDLE;
                end
            end
        end
    end

    assign bus.sel        = sel_q;
    assign bus.en         = en_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer (DWELL_W=8, GAP_CYCLES=1); outputs checked as {sel,en,busy,done,frame_tick}.
module tb_scan_sequencer;
    logic clk;
    logic rst_n;
    int   total;
    int   passed;
    int   fails;

    scan_sequencer_if #(.DWELL_W(8)) bus ();

    scan_sequencer #(.DWELL_W(8), .GAP_CYCLES(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] ex(input int s, input bit e, input bit b, input bit d, input bit f);
        return {3'(s), e, b, d, f};
    endfunction

    task automatic check(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        obs = {bus.sel, bus.en, bus.busy, bus.done, bus.frame_tick};
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed sel/en/busy/done/tick=%b required %b", tag, obs, exp);
        end
    endtask

    initial begin
        total  = 0;
        passed = 0;
        fails  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.mode  = 1'b0;
        bus.mask  = 8'h00;
        bus.dwell = 8'd0;
        tick();
        tick();
        check("reset", ex(0, 0, 0, 0, 0));
        rst_n = 1'b1;

        // One-shot, mask 81, dwell 2
        bus.mask = 8'h81; bus.dwell = 8'd2; bus.mode = 1'b0; bus.start = 1'b1;
        tick(); bus.start = 1'b0;
        check("os_c0_dwell1", ex(0, 1, 1, 0, 0));
        tick(); check("os_c0_dwell2", ex(0, 1, 1, 0, 0));
        tick(); check("os_c0_gap",    ex(0, 0, 1, 0, 0));
        tick(); check("os_c7_dwell1", ex(7, 1, 1, 0, 0));
        tick(); check("os_c7_dwell2", ex(7, 1, 1, 0, 0));
        tick(); check("os_c7_gap",    ex(7, 0, 1, 0, 0));
        tick(); check("os_done",      ex(7, 0, 0, 1, 1));
        tick(); check("os_idle",      ex(7, 0, 0, 0, 0));

        // Empty mask start is ignored
        bus.mask = 8'h00; bus.start = 1'b1;
        tick(); bus.start = 1'b0;
        check("mask0_ignored", ex(7, 0, 0, 0, 0));
        tick(); check("mask0_still_idle", ex(7, 0, 0, 0, 0));

        // Zero dwell acts as one cycle
        bus.mask = 8'h10; bus.dwell = 8'd0; bus.start = 1'b1;
        tick(); bus.start = 1'b0;
        check("dwell0_en", ex(4, 1, 1, 0, 0));
        tick(); check("dwell0_gap",  ex(4, 0, 1, 0, 0));
        tick(); check("dwell0_done", ex(4, 0, 0, 1, 1));

        // Continuous, mask 0F, dwell 1: 8-cycle frames
        bus.mask = 8'h0F; bus.dwell = 8'd1; bus.mode = 1'b1; bus.start = 1'b1;
        tick(); bus.start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("cont_k%0d", k), ex((k / 2) % 4, (k % 2) == 0, 1, 0, k == 8));
            tick();
        end
        check("cont_k16_wrap", ex(0, 1, 1, 0, 1));
        bus.start = 1'b1;
        tick(); bus.start = 1'b0;
        check("cont_start_ignored", ex(0, 0, 1, 0, 0));
        tick(); check("cont_k18", ex(1, 1, 1, 0, 0));
        tick(); check("cont_k19", ex(1, 0, 1, 0, 0));
        tick(); check("cont_k20", ex(2, 1, 1, 0, 0));

        // Stop during sel=2 dwell
        bus.stop = 1'b1;
        tick(); bus.stop = 1'b0;
        check("stop_idle", ex(2, 0, 0, 0, 0));
        tick(); check("stop_no_pulse", ex(2, 0, 0, 0, 0));

        // Stop wins over start in IDLE
        bus.start = 1'b1; bus.stop = 1'b1;
        tick(); bus.start = 1'b0; bus.stop = 1'b0;
        check("stop_beats_start", ex(2, 0, 0, 0, 0));

        // Restart after stop
        bus.mode = 1'b0; bus.mask = 8'h01; bus.start = 1'b1;
        tick(); bus.start = 1'b0;
        check("restart_en", ex(0, 1, 1, 0, 0));
        tick(); check("restart_gap",  ex(0, 0, 1, 0, 0));
        tick(); check("restart_done", ex(0, 0, 0, 1, 1));

        // Reset mid-dwell in continuous mode
        bus.mode = 1'b1; bus.mask = 8'h06; bus.dwell = 8'd3; bus.start = 1'b1;
        tick(); bus.start = 1'b0;
        check("rst_pre1", ex(1, 1, 1, 0, 0));
        tick(); check("rst_pre2", ex(1, 1, 1, 0, 0));
        rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        check("rst_mid", ex(0, 0, 0, 0, 0));
        tick(); check("rst_after1", ex(0, 0, 0, 0, 0));
        tick(); check("rst_after2", ex(0, 0, 0, 0, 0));

        // Continuous, mask change 03 -> 30 takes effect at frame boundary
        bus.mode = 1'b1; bus.mask = 8'h03; bus.dwell = 8'd1; bus.start = 1'b1;
        tick(); bus.start = 1'b0;
        check("chg_c0", ex(0, 1, 1, 0, 0));
        bus.mask = 8'h30;
        tick(); check("chg_c0_gap", ex(0, 0, 1, 0, 0));
        tick(); check("chg_c1",     ex(1, 1, 1, 0, 0));
        tick(); check("chg_c1_gap", ex(1, 0, 1, 0, 0));
        tick(); check("chg_c4_wrap", ex(4, 1, 1, 0, 1));
        tick(); check("chg_c4_gap", ex(4, 0, 1, 0, 0));
        tick(); check("chg_c5",     ex(5, 1, 1, 0, 0));
        tick(); check("chg_c5_gap", ex(5, 0, 1, 0, 0));
        tick(); check("chg_c4_again", ex(4, 1, 1, 0, 1));

        // Stop in GAP
        tick(); check("chg_gap_before_stop", ex(4, 0, 1, 0, 0));
        bus.stop = 1'b1;
        tick(); bus.stop = 1'b0;
        check("stop_in_gap", ex(4, 0, 0, 0, 0));

        // Single-bit continuous: same sel repeats with gap between frames
        bus.mask = 8'h08; bus.dwell = 8'd1; bus.start = 1'b1;
        tick(); bus.start = 1'b0;
        check("single_c3", ex(3, 1, 1, 0, 0));
        tick(); check("single_gap", ex(3, 0, 1, 0, 0));
        tick(); check("single_wrap", ex(3, 1, 1, 0, 1));
        bus.stop = 1'b1;
        tick(); bus.stop = 1'b0;
        check("single_stop", ex(3, 0, 0, 0, 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
